// File: rtl/inc16_unit.sv
// Sense/adder half of the increment path: captures the address bus, waits a
// relay-settle interval, then presents addr+1 and a carry flag to the INC register.
module inc16_unit #(
  parameter int N      = 16,
  parameter int SETTLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] addr_in,
  input  logic         addr_valid,
  input  logic         ld_inc,
  output logic [N-1:0] inc_out,
  output logic         carry_out,
  output logic         inc_ready,
  output logic         busy,
  output logic         ld_err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_READY  = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  logic [1:0]   state_q,   state_d;
  logic [N-1:0] operand_q, operand_d;
  logic [3:0]   cnt_q,     cnt_d;
  logic [N-1:0] inc_q,     inc_d;
  logic         carry_q,   carry_d;
  logic         ld_err_q,  ld_err_d;

  logic addr_changed;
  assign addr_changed = addr_valid && (addr_in != operand_q);

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    state_d   = state_q;
    operand_d = operand_q;
    cnt_d     = cnt_q;
    inc_d     = inc_q;
    carry_d   = carry_q;
    ld_err_d  = ld_err_q | (ld_inc && (state_q != ST_READY));

    unique case (state_q)
      ST_IDLE: begin
        if (addr_valid) begin
          operand_d = addr_in;
          cnt_d     = CNT_INIT;
          state_d   = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!addr_valid) begin
          state_d = ST_IDLE;
        end else if (addr_changed) begin
          operand_d = addr_in;
          cnt_d     = CNT_INIT;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          inc_d   = operand_q + N'(1);
          carry_d = &operand_q;
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        // A load takes priority so the consumed result is never re-offered.
        if (ld_inc) begin
          state_d = ST_HOLD;
        end else if (!addr_valid) begin
          state_d = ST_IDLE;
        end else if (addr_changed) begin
          operand_d = addr_in;
          cnt_d     = CNT_INIT;
          state_d   = ST_SETTLE;
        end
      end
      ST_HOLD: begin
        if (!addr_valid) begin
          state_d = ST_IDLE;
        end else if (addr_changed) begin
          operand_d = addr_in;
          cnt_d     = CNT_INIT;
          state_d   = ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      operand_q <= '0;
      cnt_q     <= '0;
      inc_q     <= '0;
      carry_q   <= 1'b0;
      ld_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      cnt_q     <= cnt_d;
      inc_q     <= inc_d;
      carry_q   <= carry_d;
      ld_err_q  <= ld_err_d;
    end
  end

  assign inc_out   = inc_q;
  assign carry_out = carry_q;
  assign inc_ready = (state_q == ST_READY);
  assign busy      = (state_q == ST_SETTLE);
  assign ld_err    = ld_err_q;

endmodule

// File: tb/tb_inc16_unit.sv
// Self-checking bench for inc16_unit: an age/flag model of the bus cycle checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_inc16_unit;

  localparam int N      = 16;
  localparam int SETTLE = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] addr_in = '0;
  logic         addr_valid = 1'b0;
  logic         ld_inc = 1'b0;
  logic [N-1:0] inc_out;
  logic         carry_out, inc_ready, busy, ld_err;

  inc16_unit #(.N(N), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .addr_in(addr_in), .addr_valid(addr_valid),
    .ld_inc(ld_inc), .inc_out(inc_out), .carry_out(carry_out),
    .inc_ready(inc_ready), .busy(busy), .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [N:0] act, input logic [N:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a bus cycle is "active" from capture until addr_valid drops; its age
  // counts edges since the last capture; the result is offered once age reaches
  // SETTLE and withdrawn once consumed by a load.
  bit           m_active, m_consumed, m_carry, m_err;
  int           m_age;
  logic [N-1:0] m_op, m_res;
  logic         m_ready, m_busy;

  assign m_ready = m_active && !m_consumed && (m_age >= SETTLE);
  assign m_busy  = m_active && (m_age < SETTLE);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_consumed = 0; m_age = 0;
      m_op = '0; m_res = '0; m_carry = 0; m_err = 0;
    end else begin
      automatic bit was_ready = m_ready;
      if (ld_inc && !was_ready) m_err = 1;
      if (!m_active) begin
        if (addr_valid) begin
          m_active = 1; m_consumed = 0; m_age = 0; m_op = addr_in;
        end
      end else if (was_ready && ld_inc) begin
        m_consumed = 1;
      end else if (!addr_valid) begin
        m_active = 0;
      end else if (addr_in != m_op) begin
        m_consumed = 0; m_age = 0; m_op = addr_in;
      end else if (m_age < SETTLE) begin
        m_age = m_age + 1;
        if (m_age == SETTLE) begin
          m_res   = m_op + 16'd1;
          m_carry = (m_op == 16'hFFFF);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("inc_out",   {1'b0, inc_out},  {1'b0, m_res});
      check("carry_out", {16'b0, carry_out}, {16'b0, m_carry});
      check("inc_ready", {16'b0, inc_ready}, {16'b0, m_ready});
      check("busy",      {16'b0, busy},      {16'b0, m_busy});
      check("ld_err",    {16'b0, ld_err},    {16'b0, m_err});
    end
  end

  task automatic step(input logic av, input logic [N-1:0] a, input logic ld);
    addr_valid = av;
    addr_in    = a;
    ld_inc     = ld;
    @(posedge clk);
    #1;
  endtask

  // Literal expectations, applied to both the DUT and the model.
  task automatic expect_lit(input string tag, input logic rdy, input logic bsy,
                            input logic [N-1:0] res, input logic cy, input logic err);
    check({tag, ".ready"}, {16'b0, inc_ready}, {16'b0, rdy});
    check({tag, ".busy"},  {16'b0, busy},      {16'b0, bsy});
    check({tag, ".out"},   {1'b0, inc_out},    {1'b0, res});
    check({tag, ".carry"}, {16'b0, carry_out}, {16'b0, cy});
    check({tag, ".err"},   {16'b0, ld_err},    {16'b0, err});
    check({tag, ".model"}, {m_ready, m_res},   {rdy, res});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    expect_lit("reset", 0, 0, 16'h0000, 0, 0);
    rst_n = 1'b1;
    check_en = 1'b1;

    // Basic capture, full settle interval.
    step(1, 16'h0123, 0);
    expect_lit("cap0123", 0, 1, 16'h0000, 0, 0);
    for (int i = 0; i < SETTLE - 1; i++) begin
      step(1, 16'h0123, 0);
      expect_lit("settle0123", 0, 1, 16'h0000, 0, 0);
    end
    step(1, 16'h0123, 0);
    expect_lit("ready0124", 1, 0, 16'h0124, 0, 0);

    // Wrap-around via recapture from READY.
    step(1, 16'hFFFF, 0);
    expect_lit("capFFFF", 0, 1, 16'h0124, 0, 0);
    for (int i = 0; i < SETTLE - 1; i++) step(1, 16'hFFFF, 0);
    step(1, 16'hFFFF, 0);
    expect_lit("wrap", 1, 0, 16'h0000, 1, 0);

    // Load in READY -> HOLD; no re-capture of the same bus cycle.
    step(1, 16'hFFFF, 1);
    expect_lit("hold", 0, 0, 16'h0000, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 16'hFFFF, 0);
      expect_lit("hold_stay", 0, 0, 16'h0000, 1, 0);
    end

    // Abort mid-settle keeps the previous result.
    step(0, 16'h0000, 0);
    expect_lit("idle", 0, 0, 16'h0000, 1, 0);
    step(1, 16'h00A0, 0);
    step(1, 16'h00A0, 0);
    expect_lit("abort_busy", 0, 1, 16'h0000, 1, 0);
    step(0, 16'h00A0, 0);
    expect_lit("abort", 0, 0, 16'h0000, 1, 0);
    step(0, 16'h00A0, 0);
    step(0, 16'h00A0, 0);
    expect_lit("abort_idle", 0, 0, 16'h0000, 1, 0);

    // Recapture mid-settle restarts the interval.
    step(1, 16'h1000, 0);
    step(1, 16'h1000, 0);
    step(1, 16'h2000, 0);
    for (int i = 0; i < SETTLE - 1; i++) begin
      step(1, 16'h2000, 0);
      expect_lit("recap_settle", 0, 1, 16'h0000, 1, 0);
    end
    step(1, 16'h2000, 0);
    expect_lit("recap_ready", 1, 0, 16'h2001, 0, 0);

    // Load outside READY sets a sticky error.
    step(0, 16'h2000, 0);
    step(0, 16'h0000, 1);
    expect_lit("ld_err", 0, 0, 16'h2001, 0, 1);
    step(1, 16'h0005, 0);
    for (int i = 0; i < SETTLE - 1; i++) step(1, 16'h0005, 0);
    step(1, 16'h0005, 0);
    expect_lit("err_sticky", 1, 0, 16'h0006, 0, 1);
    step(1, 16'h0005, 1);
    expect_lit("err_hold", 0, 0, 16'h0006, 0, 1);

    // Asynchronous reset while READY.
    step(1, 16'h0123, 0);
    for (int i = 0; i < SETTLE - 1; i++) step(1, 16'h0123, 0);
    step(1, 16'h0123, 0);
    expect_lit("pre_rst", 1, 0, 16'h0124, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    expect_lit("async_rst", 0, 0, 16'h0000, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // First capture after reset needs a full settle.
    step(1, 16'h0123, 0);
    expect_lit("post_cap", 0, 1, 16'h0000, 0, 0);
    for (int i = 0; i < SETTLE - 1; i++) begin
      step(1, 16'h0123, 0);
      expect_lit("post_settle", 0, 1, 16'h0000, 0, 0);
    end
    step(1, 16'h0123, 0);
    expect_lit("post_ready", 1, 0, 16'h0124, 0, 0);

    step(0, 16'h0000, 0);
    @(negedge clk);
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
